// File: rtl/model_bus_arbiter_if.sv
// model_bus_arbiter_if: shared-bus bundle between two producers, the arbiter and one consumer.
//   req0_valid/req0_data[2:-2]/req0_ready : requester 0 beat handshake
//   req1_valid/req1_data[-2:2]/req1_ready : requester 1 beat handshake (ascending range)
//   out_valid/out_data[2:-2]/out_src/out_ready : arbitrated output beat handshake
// Modports: master = arbiter side (drives readies and the output bus),
//           slave  = environment side (producers and consumer).
interface model_bus_arbiter_if;
  logic          req0_valid;
  logic [2:-2]   req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [-2:2]   req1_data;
  logic          req1_ready;
  logic          out_valid;
  logic [2:-2]   out_data;
  logic          out_src;
  logic          out_ready;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_src
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/model_bus_arbiter.sv
// model_bus_arbiter: two-requester round-robin burst arbiter onto one registered
// 5-bit output bus with valid/ready flow control.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : model_bus_arbiter_if.master (requester handshakes + output bus)
//   lock0/1  : only with MODEL_BUS_ARB_LOCK_EN defined; holding the owner's lock
//              suppresses release on MAX_BURST (bcnt saturates)
// Parameters: MAX_BURST (beats per grant, >= 1), INIT_PRIO (first tie winner).
module model_bus_arbiter #(
  parameter int unsigned MAX_BURST = 10,
  parameter int unsigned INIT_PRIO = 0
) (
  input logic                 clk,
  input logic                 rst,
  model_bus_arbiter_if.master bus
`ifdef MODEL_BUS_ARB_LOCK_EN
  ,
  input logic                 lock0,
  input logic                 lock1
`endif
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ov_q, ov_d;
  logic [2:-2]   od_q, od_d;
  logic          os_q, os_d;

  logic          r0_rdy, r1_rdy;
  logic          slot_open;
  logic          own_valid, oth_valid, own_lock;
  logic          xfer, rel;
  logic [2:-2]   map1;

  // Requester 1 maps positionally: leftmost bit (-2) lands on out_data[2].
  always_comb begin
    map1 = '0;
    for (int k = 0; k < 5; k++) begin
      map1[2-k] = bus.req1_data[-2+k];
    end
  end

  // Lock of the current owner; absent feature behaves as lock tied low.
  always_comb begin
    own_lock = 1'b0;
`ifdef MODEL_BUS_ARB_LOCK_EN
    if (state_q == OWN0) own_lock = lock0;
    else if (state_q == OWN1) own_lock = lock1;
`endif
  end

  // Next-state, grant and output-register update.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    bcnt_d    = bcnt_q;
    ov_d      = ov_q;
    od_d      = od_q;
    os_d      = os_q;
    r0_rdy    = 1'b0;
    r1_rdy    = 1'b0;
    own_valid = 1'b0;
    oth_valid = 1'b0;
    rel       = 1'b0;
    slot_open = !ov_q || bus.out_ready;

    case (state_q)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) state_d = prio_q ? OWN1 : OWN0;
        else if (bus.req0_valid)              state_d = OWN0;
        else if (bus.req1_valid)              state_d = OWN1;
      end
      OWN0: begin
        r0_rdy    = slot_open;
        own_valid = bus.req0_valid;
        oth_valid = bus.req1_valid;
      end
      OWN1: begin
        r1_rdy    = slot_open;
        own_valid = bus.req1_valid;
        oth_valid = bus.req0_valid;
      end
      default: state_d = IDLE;
    endcase

    xfer = own_valid && (r0_rdy || r1_rdy);

    if (bus.out_ready) ov_d = 1'b0;
    if (xfer) begin
      ov_d   = 1'b1;
      od_d   = (state_q == OWN1) ? map1 : bus.req0_data;
      os_d   = (state_q == OWN1);
      bcnt_d = (bcnt_q == BMAX) ? bcnt_q : bcnt_q + BW'(1);
    end

    // Release hands priority to the other side; the releaser must revisit IDLE.
    rel = (state_q != IDLE) &&
          (!own_valid || (xfer && (bcnt_d == BMAX) && !own_lock));
    if (rel) begin
      prio_d  = (state_q == OWN0);
      bcnt_d  = '0;
      state_d = oth_valid ? ((state_q == OWN0) ? OWN1 : OWN0) : IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'(INIT_PRIO);
      bcnt_q  <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      bcnt_q  <= bcnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      os_q    <= os_d;
    end
  end

  assign bus.req0_ready = r0_rdy;
  assign bus.req1_ready = r1_rdy;
  assign bus.out_valid  = ov_q;
  assign bus.out_data   = od_q;
  assign bus.out_src    = os_q;

endmodule

// File: tb/tb_model_bus_arbiter.sv
// tb_model_bus_arbiter: directed checks of model_bus_arbiter.
// dut_a uses MAX_BURST=10, dut_b uses MAX_BURST=3; both INIT_PRIO=0.
module tb_model_bus_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   fails;

  model_bus_arbiter_if bus_a ();
  model_bus_arbiter_if bus_b ();

  model_bus_arbiter #(.MAX_BURST(10), .INIT_PRIO(0)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
`ifdef MODEL_BUS_ARB_LOCK_EN
    ,
    .lock0(1'b0),
    .lock1(1'b0)
`endif
  );

  model_bus_arbiter #(.MAX_BURST(3), .INIT_PRIO(0)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
`ifdef MODEL_BUS_ARB_LOCK_EN
    ,
    .lock0(1'b0),
    .lock1(1'b0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus_a.req0_valid = 1'b0; bus_a.req1_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_a.req0_data  = '0;   bus_a.req1_data  = '0;
    bus_b.req0_valid = 1'b0; bus_b.req1_valid = 1'b0; bus_b.out_ready = 1'b1;
    bus_b.req0_data  = '0;   bus_b.req1_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.out_data !== 5'b00000 || bus_a.out_src !== 1'b0) begin
      fails++;
      $display("FAIL reset_out_a: valid=%b data=%b src=%b, want 0 00000 0",
               bus_a.out_valid, bus_a.out_data, bus_a.out_src);
    end
    checks++;
    if (bus_a.req0_ready !== 1'b0 || bus_a.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_a: r0=%b r1=%b, want 0 0", bus_a.req0_ready, bus_a.req1_ready);
    end
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.req0_ready !== 1'b0 || bus_b.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: valid=%b r0=%b r1=%b, want 0 0 0",
               bus_b.out_valid, bus_b.req0_ready, bus_b.req1_ready);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_req0_basic();
    quiet();
    bus_a.req0_valid = 1'b1;
    bus_a.req0_data  = 5'b10110;
    #1;
    checks++;
    if (bus_a.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_idle_ready: got %b want 0", bus_a.req0_ready);
    end
    tick();
    checks++;
    if (bus_a.req0_ready !== 1'b1 || bus_a.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_c1: ready=%b out_valid=%b, want 1 0", bus_a.req0_ready, bus_a.out_valid);
    end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 5'b10110 || bus_a.out_src !== 1'b0) begin
      fails++;
      $display("FAIL basic_c2: valid=%b data=%b src=%b, want 1 10110 0",
               bus_a.out_valid, bus_a.out_data, bus_a.out_src);
    end
    bus_a.req0_valid = 1'b0;
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_drain: valid=%b ready=%b, want 0 0", bus_a.out_valid, bus_a.req0_ready);
    end
    tick();
  endtask

  task automatic test_req1_map();
    logic [4:0] pat [2];
    logic [4:0] exp [2];
    pat[0] = 5'b10000; exp[0] = 5'b10000;
    pat[1] = 5'b11010; exp[1] = 5'b11010;
    for (int p = 0; p < 2; p++) begin
      quiet();
      bus_a.req1_valid = 1'b1;
      bus_a.req1_data  = pat[p];
      tick();
      checks++;
      if (bus_a.req1_ready !== 1'b1 || bus_a.req0_ready !== 1'b0) begin
        fails++;
        $display("FAIL map_ready%0d: r1=%b r0=%b, want 1 0", p, bus_a.req1_ready, bus_a.req0_ready);
      end
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== exp[p] || bus_a.out_src !== 1'b1) begin
        fails++;
        $display("FAIL map_data%0d: valid=%b data=%b src=%b, want 1 %b 1",
                 p, bus_a.out_valid, bus_a.out_data, bus_a.out_src, exp[p]);
      end
      if (p == 0) begin
        checks++;
        if (bus_a.out_data[2] !== 1'b1) begin
          fails++;
          $display("FAIL map_bit2: got %b want 1", bus_a.out_data[2]);
        end
      end
      bus_a.req1_valid = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_d;
    logic       exp_s;
    quiet();
    do_reset();
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 5'b10110;
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 5'b01101;
    tick();
    for (int i = 0; i < 30; i++) begin
      tick();
      exp_s = 1'((i / 10) % 2);
      exp_d = exp_s ? 5'b01101 : 5'b10110;
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_src !== exp_s || bus_a.out_data !== exp_d) begin
        fails++;
        $display("FAIL rr_beat%0d: valid=%b src=%b data=%b, want 1 %b %b",
                 i, bus_a.out_valid, bus_a.out_src, bus_a.out_data, exp_s, exp_d);
      end
    end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_burst3();
    logic exp_v, exp_r;
    quiet();
    do_reset();
    bus_b.req0_valid = 1'b1;
    bus_b.req0_data  = 5'b00111;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_r = ((k % 4) != 0);
      exp_v = (k >= 2) && (((k - 2) % 4) != 3);
      checks++;
      if (bus_b.req0_ready !== exp_r || bus_b.out_valid !== exp_v) begin
        fails++;
        $display("FAIL burst3_c%0d: ready=%b valid=%b, want %b %b",
                 k, bus_b.req0_ready, bus_b.out_valid, exp_r, exp_v);
      end
    end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_stall();
    quiet();
    do_reset();
    bus_a.req0_valid = 1'b1;
    bus_a.req0_data  = 5'b11001;
    tick();
    tick();
    bus_a.out_ready = 1'b0;
    bus_a.req0_data = 5'b00110;
    #1;
    checks++;
    if (bus_a.req0_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_ready_drop: got %b want 0", bus_a.req0_ready);
    end
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 5'b11001 || bus_a.req0_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%b data=%b ready=%b, want 1 11001 0",
                 s, bus_a.out_valid, bus_a.out_data, bus_a.req0_ready);
      end
    end
    bus_a.out_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_resume_ready: got %b want 1", bus_a.req0_ready);
    end
    // Nine more beats complete the 10-beat burst only if the stall did not count.
    for (int e = 1; e <= 9; e++) begin
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 5'b00110 ||
          bus_a.req0_ready !== (e < 9)) begin
        fails++;
        $display("FAIL stall_beat%0d: valid=%b data=%b ready=%b, want 1 00110 %b",
                 e, bus_a.out_valid, bus_a.out_data, bus_a.req0_ready, (e < 9));
      end
    end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.req0_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_bubble: valid=%b ready=%b, want 0 1", bus_a.out_valid, bus_a.req0_ready);
    end
    quiet();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    quiet();
    do_reset();
    // Burst from requester 0, released by valid low, leaves priority on requester 1.
    bus_a.req0_valid = 1'b1; bus_a.req0_data = 5'b01010;
    tick();
    tick();
    bus_a.req0_valid = 1'b0;
    tick();
    bus_a.req1_valid = 1'b1; bus_a.req1_data = 5'b00011;
    tick();
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_src !== 1'b1 || bus_a.req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_setup: valid=%b src=%b r1=%b, want 1 1 1",
               bus_a.out_valid, bus_a.out_src, bus_a.req1_ready);
    end
    bus_a.req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.req0_ready !== 1'b0 || bus_a.req1_ready !== 1'b0 ||
        bus_a.out_data !== 5'b00000) begin
      fails++;
      $display("FAIL rstmid_async: valid=%b r0=%b r1=%b data=%b, want 0 0 0 00000",
               bus_a.out_valid, bus_a.req0_ready, bus_a.req1_ready, bus_a.out_data);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (bus_a.req0_ready !== 1'b1 || bus_a.req1_ready !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_tie: r0=%b r1=%b, want 1 0", bus_a.req0_ready, bus_a.req1_ready);
    end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_src !== 1'b0 || bus_a.out_data !== 5'b01010) begin
      fails++;
      $display("FAIL rstmid_first: valid=%b src=%b data=%b, want 1 0 01010",
               bus_a.out_valid, bus_a.out_src, bus_a.out_data);
    end
    quiet();
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    quiet();
    test_reset();
    test_req0_basic();
    test_req1_map();
    test_round_robin();
    test_burst3();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/model_bus_arbiter.md
# model_bus_arbiter

Two-requester round-robin arbiter that shares one registered 5-bit output bus between producers of the `model` cell family. Requester 0 presents a descending-range bus `[2:-2]`; requester 1 presents an ascending-range bus `[-2:2]`. The block sequences bursts from each requester onto a single `[2:-2]` output with valid/ready flow control. It sits between two producer instances and one consumer of the shared bus.

## Interface
Parameters:
- `MAX_BURST`, default 10: maximum beats per grant; legal range ≥ 1.
- `INIT_PRIO`, default 0: requester that wins the first tie after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous active-high reset
- `req0_valid`  in  1  requester 0 beat valid
- `req0_data`  in  [2:-2]  requester 0 beat
- `req0_ready`  out  1  requester 0 beat accepted
- `req1_valid`  in  1  requester 1 beat valid
- `req1_data`  in  [-2:2]  requester 1 beat
- `req1_ready`  out  1  requester 1 beat accepted
- `out_valid`  out  1  output register holds a beat
- `out_data`  out  [2:-2]  output beat
- `out_src`  out  1  requester that produced `out_data`
- `out_ready`  in  1  consumer accepts the output beat

## Operation
- FSM states: IDLE, OWN0, OWN1.
- Registers: `prio` (1 bit), burst counter `bcnt` (width `$clog2(MAX_BURST+1)`), output register.
- IDLE:
  - both readies are 0.
  - If exactly one valid is high, go to that requester's OWN state.
  - If both are high, go to OWN`prio`.
  - If neither is high, stay in IDLE.
- OWNx:
  - `reqx_ready = !out_valid || out_ready`; the other requester's ready is 0.
  - A transfer is `reqx_valid && reqx_ready`. It loads the output register, sets `out_src = x`, and increments `bcnt`.
- Release from OWNx happens when either:
  - `reqx_valid` is 0 in any OWNx cycle, or
  - a transfer brings `bcnt` to `MAX_BURST`.
- On release:
  - `prio` is set to the other requester, and `bcnt` is cleared.
  - Next state is OWN(other) if the other requester's valid is high that cycle; otherwise IDLE.
  - The releasing requester never re-enters OWN directly. It passes through IDLE first, which costs one bubble.
- Data mapping:
  - `req0_data` maps bit-for-bit: `out_data[i] = req0_data[i]`.
  - `req1_data` maps positionally, left to right: `out_data[2-k] = req1_data[-2+k]` for k = 0..4.
- Output register:
  - `out_valid` clears on `out_ready` unless a new transfer loads in the same cycle.
  - On load, `out_valid` stays 1.
  - `out_data` and `out_src` hold their values while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `prio = INIT_PRIO`, `bcnt = 0`, `out_valid = 0`, `out_data = 0`, `out_src = 0`, `req0_ready = 0`, `req1_ready = 0`.
- Readies are combinational from state, `out_valid` and `out_ready`. No valid-to-ready combinational path exists.
- Latency: valid rises in IDLE at cycle n → OWN and ready at n+1 → `out_valid` at n+2.
- Throughput: one beat per cycle inside a burst when `out_ready` is held high.
- Back-to-back handover: last beat of requester A at cycle m, first beat of B at cycle m+1, with no bubble.
- A stall (`out_ready = 0` with `out_valid = 1`) freezes the owner; `bcnt` does not advance.
- Reset asserted mid-burst:
  - all state returns to reset values immediately;
  - the in-flight beat in the output register is discarded;
  - readies drop asynchronously.

## Configuration
- `MODEL_BUS_ARB_LOCK_EN` defined:
  - adds input ports `lock0` and `lock1` (1 bit each, after `req1_ready`).
  - While the owner's lock is high, release on `MAX_BURST` is suppressed and `bcnt` saturates at `MAX_BURST`.
  - Release on valid low still applies.
- Macro undefined: no lock ports; behaviour is identical to locks tied to 0.

## Test plan
- Reset, then `req0_valid = 1` with `req0_data = 5'b10110` and `out_ready = 1` → `req0_ready` high at cycle 1, `out_valid = 1`, `out_data = 5'b10110`, `out_src = 0` at cycle 2.
- `req1_data` with only bit -2 set, as the only request → `out_data[2] = 1`, all other `out_data` bits 0, `out_src = 1`.
- Both valid continuously, `MAX_BURST = 10`, `INIT_PRIO = 0` → 10 beats from requester 0, then 10 from requester 1, alternating with no bubble at handover.
- Requester 0 alone, continuously valid, `MAX_BURST = 3` → 3 beats, one IDLE bubble, 3 beats, repeating.
- `out_ready = 0` for 5 cycles after the first beat → `out_data` stable, owner ready 0, `bcnt` unchanged; the burst resumes when `out_ready` returns to 1.
- Assert `rst` mid-burst with `out_valid = 1` → `out_valid` and both readies go to 0 at once; after release, the first tie goes to `INIT_PRIO`.
